// File: rtl/tick_timer.sv
// ============================================================================
// Module   : tick_timer
// Brief    : Programmable periodic / one-shot tick generator with a wrapping
//            tick counter. Define TICK_TIMER_PRESCALER_EN to build the
//            clock prescaler; otherwise one stroke is taken per clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer #(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_W     = 8,
    parameter int DEFAULT_PERIOD = 2_000_000,
    parameter int COUNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    output logic                  tick,
    output logic                  running,
    output logic [COUNT_W-1:0]    tick_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_period;
    logic [WIDTH-1:0]   r_cnt;
    logic               r_mode;
    logic               r_tick;
    logic [COUNT_W-1:0] r_tick_count;

    logic               w_stroke;
    logic               w_terminal;
    logic [WIDTH-1:0]   w_last;
    logic               w_cfg_fire;
    logic               w_start_fire;

    assign w_cfg_fire   = cfg_valid && (r_state == S_IDLE);
    assign w_start_fire = start && !stop && (r_state == S_IDLE);

    // A zero period behaves as a period of one, so the last count is 0 either way.
    assign w_last     = (r_period == '0) ? '0 : (r_period - WIDTH'(1));
    assign w_terminal = (r_cnt == w_last);

`ifdef TICK_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pre;

    assign w_stroke = (r_pre == r_prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
            r_pre      <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_cfg_fire) begin
                r_prescale <= cfg_prescale;
            end
            if (w_start_fire) begin
                r_pre <= '0;
            end
        end else if (!stop) begin
            r_pre <= w_stroke ? '0 : (r_pre + PRESCALE_W'(1));
        end
    end
`else
    logic w_unused_prescale;

    assign w_stroke          = 1'b1;
    assign w_unused_prescale = ^cfg_prescale;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_period     <= WIDTH'(DEFAULT_PERIOD);
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_tick       <= 1'b0;
            r_tick_count <= '0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_fire) begin
                        r_period     <= cfg_period;
                        r_tick_count <= '0;
                    end
                    if (w_start_fire) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_mode  <= mode;
                    end
                end
                S_RUN: begin
                    // Stop outranks a coincident terminal count: no tick, no count.
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (w_stroke) begin
                        if (w_terminal) begin
                            r_cnt        <= '0;
                            r_tick       <= 1'b1;
                            r_tick_count <= r_tick_count + COUNT_W'(1);
                            if (r_mode) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + WIDTH'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready  = (r_state == S_IDLE);
    assign running    = (r_state == S_RUN);
    assign tick       = r_tick;
    assign tick_count = r_tick_count;

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ============================================================================
// Module   : tb_tick_timer
// Brief    : Scoreboard bench for tick_timer; expected ticks are queued when a
//            run is started and popped as the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_timer;

    localparam int WIDTH          = 32;
    localparam int PRESCALE_W     = 8;
    localparam int DEFAULT_PERIOD = 20;
    localparam int COUNT_W        = 4;
`ifdef TICK_TIMER_PRESCALER_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  mode = 1'b0;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [WIDTH-1:0]      cfg_period = '0;
    logic [PRESCALE_W-1:0] cfg_prescale = '0;
    logic                  tick;
    logic                  running;
    logic [COUNT_W-1:0]    tick_count;

    tick_timer #(
        .WIDTH          (WIDTH),
        .PRESCALE_W     (PRESCALE_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .COUNT_W        (COUNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_prescale (cfg_prescale),
        .tick         (tick),
        .running      (running),
        .tick_count   (tick_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q_exp[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every tick the DUT raises must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && tick) begin
            if (q_exp.size() == 0) begin
                check("spurious_tick", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_count", int'(tick_count), e.cnt);
            end
        end
    end

    task automatic config_timer(input int p, input int s);
        cfg_valid    = 1'b1;
        cfg_period   = WIDTH'(p);
        cfg_prescale = PRESCALE_W'(s);
        @(negedge clk);
        cfg_valid    = 1'b0;
    endtask

    task automatic start_run(input bit m, input int p, input int s, input int n, input int base);
        int se;
        int pe;
        int k;
        exp_t e;
        se = PRE_EN ? s : 0;
        pe = (p == 0) ? 1 : p;
        k  = cyc + 1;
        for (int i = 1; i <= n; i++) begin
            e.cyc = k + i * pe * (se + 1);
            e.cnt = (base + i) % (1 << COUNT_W);
            q_exp.push_back(e);
        end
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    int se3;

    initial begin
        se3 = PRE_EN ? 1 : 0;
        repeat (2) @(negedge clk);
        check("rst_running", int'(running), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_tick_count", int'(tick_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // Periodic, P=4, S=0
        config_timer(4, 0);
        start_run(1'b0, 4, 0, 3, 0);
        check("p4_running", int'(running), 1);
        repeat (12) @(negedge clk);
        check("p4_count3", int'(tick_count), 3);
        stop_pulse();
        check("p4_stop_running", int'(running), 0);
        check("p4_stop_tick", int'(tick), 0);
        check("p4_pending", q_exp.size(), 0);

        // One-shot, P=3, S=1
        config_timer(3, 1);
        start_run(1'b1, 3, 1, 1, 0);
        repeat (3 * (se3 + 1)) @(negedge clk);
        check("os_tick", int'(tick), 1);
        check("os_running", int'(running), 0);
        check("os_cfg_ready", int'(cfg_ready), 1);
        repeat (50) @(negedge clk);
        check("os_idle_running", int'(running), 0);
        check("os_pending", q_exp.size(), 0);

        // Stop coinciding with terminal count, P=5
        config_timer(5, 0);
        start_run(1'b0, 5, 0, 1, 0);
        repeat (9) @(negedge clk);
        stop_pulse();
        check("tc_stop_running", int'(running), 0);
        check("tc_stop_tick", int'(tick), 0);
        check("tc_stop_count", int'(tick_count), 1);
        start_run(1'b0, 5, 0, 1, 1);
        repeat (5) @(negedge clk);
        check("restart_tick", int'(tick), 1);
        stop_pulse();
        check("restart_pending", q_exp.size(), 0);

        // Config request held during RUN
        start_run(1'b0, 5, 0, 0, 2);
        cfg_valid  = 1'b1;
        cfg_period = WIDTH'(7);
        @(negedge clk);
        check("stall_ready0", int'(cfg_ready), 0);
        repeat (2) @(negedge clk);
        check("stall_ready1", int'(cfg_ready), 0);
        check("stall_count", int'(tick_count), 2);
        stop_pulse();
        check("stall_ready_idle", int'(cfg_ready), 1);
        check("stall_count_held", int'(tick_count), 2);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("stall_count_clr", int'(tick_count), 0);
        start_run(1'b0, 7, 0, 3, 0);
        repeat (21) @(negedge clk);
        check("p7_count3", int'(tick_count), 3);
        stop_pulse();
        check("p7_pending", q_exp.size(), 0);

        // P=1 continuous tick with counter wrap
        config_timer(1, 0);
        start_run(1'b0, 1, 0, 17, 0);
        repeat (16) @(negedge clk);
        check("p1_tick_high", int'(tick), 1);
        check("p1_wrap", int'(tick_count), 0);
        @(negedge clk);
        stop_pulse();
        check("p1_stop_tick", int'(tick), 0);
        check("p1_pending", q_exp.size(), 0);

        // Asynchronous reset mid-run at cnt=2
        config_timer(5, 0);
        start_run(1'b0, 5, 0, 1, 0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_running", int'(running), 0);
        check("arst_tick", int'(tick), 0);
        check("arst_cfg_ready", int'(cfg_ready), 1);
        check("arst_tick_count", int'(tick_count), 0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_pending", q_exp.size(), 0);
        start_run(1'b0, DEFAULT_PERIOD, 0, 1, 0);
        repeat (DEFAULT_PERIOD + 1) @(negedge clk);
        stop_pulse();
        check("default_pending", q_exp.size(), 0);
        check("default_count", int'(tick_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
